// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the serial multiply-accumulate sequencer.
//   state_t    : sequencer states (IDLE, START, WAIT, ACC)
//   MUL_CYCLES : run length of the attached 8x8 serial multiplier
//   DEF_W      : default operand width
//   DEF_ACC_W  : default accumulator / result width
// ---------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACC   = 2'd3
  } state_t;

  localparam int MUL_CYCLES = 8;
  localparam int DEF_W      = 8;
  localparam int DEF_ACC_W  = 24;

endpackage

// File: rtl/serial_mac_ctrl_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding operand pairs between the upstream source and
// the multiplier sequencer. Push and pop in the same cycle are both honoured.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   : write request and data (ignored while full)
//   pop, rdata    : read request (ignored while empty) and head-of-queue data
//   full, empty   : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // The occupancy count is kept one bit wider than the pointers so that
  // full and empty are distinguishable when the pointers coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_mac_ctrl.sv
// ---------------------------------------------------------------------------
// serial_mac_ctrl
// Sequencer around an 8x8 signed serial multiplier. Operand pairs are
// buffered in a FIFO, each pair drives one multiplier run, and the signed
// products are summed into a wide accumulator. A pair flagged in_last closes
// the vector and presents the dot product on the result port.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_last : operand pair input handshake
//   mul_start/mul_a/mul_b          : multiplier launch pulse and operands
//   mul_ready/mul_product          : multiplier done flag and 2W-bit product
//   res_valid/res_ready/res_data/res_ovf : result output handshake
//   busy                           : sequencer active or FIFO non-empty
// ---------------------------------------------------------------------------
module serial_mac_ctrl
  import mac_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic             mul_ready,
  input  logic [2*W-1:0]   mul_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  localparam int FW = 2*W + 1;

  state_t                   state_q, state_d;
  logic [W-1:0]             mul_a_q, mul_a_d;
  logic [W-1:0]             mul_b_q, mul_b_d;
  logic                     last_q, last_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic                     res_valid_q, res_valid_d;
  logic [ACC_W-1:0]         res_data_q, res_data_d;
  logic                     res_ovf_q, res_ovf_d;

  logic [FW-1:0]            fifo_wdata, fifo_rdata;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_n;
  logic                     ovf_now;

  assign fifo_wdata = {in_last, in_a, in_b};
  assign fifo_push  = in_valid && in_ready;
  assign in_ready   = !fifo_full;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Product is sign-extended to the accumulator width; the sum wraps in
  // two's complement. Overflow occurs when both addends share a sign and
  // the sum's sign differs from it.
  assign prod_ext = ACC_W'($signed(mul_product));
  assign acc_n    = acc_q + prod_ext;
  assign ovf_now  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (acc_n[ACC_W-1] != acc_q[ACC_W-1]);

  // Next-state and datapath control. A new pair is launched only while no
  // result is waiting, so a finished vector can never be overwritten; the
  // FIFO keeps absorbing pairs in the meantime.
  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    last_d      = last_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    fifo_pop    = 1'b0;
    mul_start   = 1'b0;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !res_valid_q) begin
          fifo_pop                   = 1'b1;
          {last_d, mul_a_d, mul_b_d} = fifo_rdata;
          state_d                    = START;
        end
      end
      START: begin
        mul_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mul_ready) begin
          state_d = ACC;
        end
      end
      ACC: begin
        if (last_q) begin
          res_data_d  = acc_n;
          res_ovf_d   = ovf_q || ovf_now;
          res_valid_d = 1'b1;
          acc_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = acc_n;
          ovf_d = ovf_q || ovf_now;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_serial_mac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_mac_ctrl
// Bench for serial_mac_ctrl. Two instances: dut0 with the default 24-bit
// accumulator and dut1 with a 17-bit accumulator for the wrap case. Each is
// paired with a behavioural 8x8 signed serial multiplier. Expected results
// are computed from the pushed operands and queued; they are popped as the
// DUT hands results over.
// ---------------------------------------------------------------------------
module tb_serial_mac_ctrl;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        in_last = 1'b0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic        res_ready0 = 1'b0, res_ready1 = 1'b0;

  logic        in_ready0, mul_start0, res_valid0, res_ovf0, busy0;
  logic [7:0]  mul_a0, mul_b0;
  logic [23:0] res_data0;
  logic        in_ready1, mul_start1, res_valid1, res_ovf1, busy1;
  logic [7:0]  mul_a1, mul_b1;
  logic [16:0] res_data1;

  logic        mr0 = 1'b1, mr1 = 1'b1;
  logic [15:0] mp0 = '0, mp1 = '0;
  int          mcnt0 = 0, mcnt1 = 0;
  int          start_cnt0 = 0;

  int          checks = 0;
  int          failures = 0;
  longint      exp_data_q[$];
  bit          exp_ovf_q[$];
  longint      macc = 0;
  bit          movf = 1'b0;

  always #5 clk = ~clk;

  serial_mac_ctrl #(.W(8), .ACC_W(24), .DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mul_start0),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_ready(mr0), .mul_product(mp0),
    .res_valid(res_valid0), .res_ready(res_ready0), .res_data(res_data0),
    .res_ovf(res_ovf0), .busy(busy0)
  );

  serial_mac_ctrl #(.W(8), .ACC_W(17), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mul_start1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_ready(mr1), .mul_product(mp1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1),
    .res_ovf(res_ovf1), .busy(busy1)
  );

  // Serial multiplier models: not reset, ready drops on start and rises
  // MUL_CYCLES cycles after the start pulse with the full signed product.
  always @(posedge clk) begin
    if (mul_start0) begin
      mcnt0 <= MUL_CYCLES - 1;
      mr0   <= 1'b0;
    end else if (mcnt0 != 0) begin
      mcnt0 <= mcnt0 - 1;
      if (mcnt0 == 1) begin
        mr0 <= 1'b1;
        mp0 <= $signed({{8{mul_a0[7]}}, mul_a0}) * $signed({{8{mul_b0[7]}}, mul_b0});
      end
    end
    if (mul_start0) start_cnt0 <= start_cnt0 + 1;
  end

  always @(posedge clk) begin
    if (mul_start1) begin
      mcnt1 <= MUL_CYCLES - 1;
      mr1   <= 1'b0;
    end else if (mcnt1 != 0) begin
      mcnt1 <= mcnt1 - 1;
      if (mcnt1 == 1) begin
        mr1 <= 1'b1;
        mp1 <= $signed({{8{mul_a1[7]}}, mul_a1}) * $signed({{8{mul_b1[7]}}, mul_b1});
      end
    end
  end

  function automatic longint wrap_to(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  // Pushes one pair into the selected DUT (entered and left on a negedge)
  // and updates the reference dot-product model.
  task automatic push_pair(input int sel, input logic signed [7:0] a,
                           input logic signed [7:0] b, input bit last,
                           output bit stalled);
    int     n;
    int     w;
    longint s;
    longint half;
    n       = 0;
    stalled = 1'b0;
    in_a    = a;
    in_b    = b;
    in_last = last;
    if (sel == 1) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    while (!((sel == 1) ? in_ready1 : in_ready0) && n < 300) begin
      stalled = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_timeout: in_ready=0 expected 1 within 300 cycles");
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    w    = (sel == 1) ? 17 : 24;
    half = longint'(1) << (w - 1);
    s    = macc + longint'(a) * longint'(b);
    if (s >= half || s < -half) movf = 1'b1;
    macc = wrap_to(s, w);
    if (last) begin
      exp_data_q.push_back(macc);
      exp_ovf_q.push_back(movf);
      macc = 0;
      movf = 1'b0;
    end
  endtask

  // Waits (bounded) for a result from the selected DUT and accepts it.
  task automatic get_result(input int sel, output longint d, output bit o,
                            output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    d  = 0;
    o  = 1'b0;
    while (n < 300) begin
      if ((sel == 1) ? res_valid1 : res_valid0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!ok) return;
    d = (sel == 1) ? longint'($signed(res_data1)) : longint'($signed(res_data0));
    o = (sel == 1) ? res_ovf1 : res_ovf0;
    if (sel == 1) res_ready1 = 1'b1; else res_ready0 = 1'b1;
    @(negedge clk);
    res_ready0 = 1'b0;
    res_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready0, mul_start0, mul_a0, mul_b0, res_valid0, res_ovf0, busy0} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got rdy=%0b st=%0b a=%0h b=%0h v=%0b ovf=%0b busy=%0b expected 1 0 0 0 0 0 0",
               in_ready0, mul_start0, mul_a0, mul_b0, res_valid0, res_ovf0, busy0);
    end
    checks++;
    if (res_data0 !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %0h expected 0", res_data0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got rdy0=%0b busy0=%0b rdy1=%0b busy1=%0b expected 1 0 1 0",
               in_ready0, busy0, in_ready1, busy1);
    end
  endtask

  task automatic test_single_latency();
    bit     st;
    bit     ok;
    bit     o;
    longint d;
    int     n;
    push_pair(0, 8'sd3, -8'sd5, 1'b1, st);
    n = 0;
    while (n < 40 && !res_valid0) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        checks++;
        if (mul_a0 !== 8'h03 || mul_b0 !== 8'hFB) begin
          failures++;
          $display("[TB] FAIL run_operands: got a=%0h b=%0h expected 3 fb", mul_a0, mul_b0);
        end
      end
    end
    checks++;
    if (n !== 11) begin
      failures++;
      $display("[TB] FAIL latency: got %0d cycles expected 11", n);
    end
    get_result(0, d, o, ok);
    checks++;
    if (!ok || exp_data_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL single_result: got no result expected -15");
    end else if (d !== exp_data_q.pop_front() || o !== exp_ovf_q.pop_front() || d !== -15) begin
      failures++;
      $display("[TB] FAIL single_result: got %0d ovf=%0b expected -15 ovf=0", d, o);
    end
  endtask

  task automatic test_vector();
    bit     st;
    bit     ok;
    bit     o;
    longint d;
    push_pair(0, 8'sd7, 8'sd9, 1'b0, st);
    push_pair(0, -8'sd128, -8'sd128, 1'b0, st);
    push_pair(0, 8'sd127, -8'sd1, 1'b1, st);
    get_result(0, d, o, ok);
    checks++;
    if (!ok || exp_data_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL vector_result: got no result expected 16320");
    end else if (d !== exp_data_q.pop_front() || o !== exp_ovf_q.pop_front() || d !== 16320) begin
      failures++;
      $display("[TB] FAIL vector_result: got %0d ovf=%0b expected 16320 ovf=0", d, o);
    end
  endtask

  task automatic test_back_to_back();
    bit     st;
    bit     any_stall;
    bit     ok;
    bit     o;
    longint d;
    longint e;
    bit     eo;
    logic signed [7:0] av [6] = '{8'sd1, 8'sd3, 8'sd5, -8'sd1, 8'sd8, 8'sd10};
    logic signed [7:0] bv [6] = '{8'sd2, 8'sd4, 8'sd6, 8'sd7, -8'sd9, 8'sd10};
    any_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_pair(0, av[i], bv[i], (i == 2 || i == 5), st);
      if (st) any_stall = 1'b1;
    end
    checks++;
    if (any_stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_backpressure: got in_ready never low expected a stall on push 6");
    end
    for (int i = 0; i < 2; i++) begin
      get_result(0, d, o, ok);
      checks++;
      if (!ok || exp_data_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL b2b_result%0d: got no result expected a queued result", i);
      end else begin
        e  = exp_data_q.pop_front();
        eo = exp_ovf_q.pop_front();
        if (d !== e || o !== eo) begin
          failures++;
          $display("[TB] FAIL b2b_result%0d: got %0d ovf=%0b expected %0d ovf=%0b", i, d, o, e, eo);
        end
      end
    end
  endtask

  task automatic test_hold_result();
    bit     st;
    bit     ok;
    bit     o;
    bit     unstable;
    longint d;
    longint e;
    bit     eo;
    logic [23:0] held;
    int     starts;
    int     n;
    push_pair(0, 8'sd1, 8'sd2, 1'b0, st);
    push_pair(0, 8'sd3, 8'sd4, 1'b1, st);
    push_pair(0, 8'sd5, 8'sd6, 1'b1, st);
    n = 0;
    while (!res_valid0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    held     = res_data0;
    starts   = start_cnt0;
    unstable = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (!res_valid0 || res_data0 !== held) unstable = 1'b1;
    end
    checks++;
    if (unstable || held !== 24'd14) begin
      failures++;
      $display("[TB] FAIL hold_stable: got data=%0d unstable=%0b expected 14 held", held, unstable);
    end
    checks++;
    if (start_cnt0 !== starts) begin
      failures++;
      $display("[TB] FAIL hold_no_launch: got %0d starts expected %0d", start_cnt0, starts);
    end
    for (int i = 0; i < 2; i++) begin
      get_result(0, d, o, ok);
      checks++;
      if (!ok || exp_data_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL hold_result%0d: got no result expected a queued result", i);
      end else begin
        e  = exp_data_q.pop_front();
        eo = exp_ovf_q.pop_front();
        if (d !== e || o !== eo) begin
          failures++;
          $display("[TB] FAIL hold_result%0d: got %0d ovf=%0b expected %0d ovf=%0b", i, d, o, e, eo);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit     st;
    bit     ok;
    bit     o;
    longint d;
    longint e;
    bit     eo;
    for (int i = 0; i < 5; i++) begin
      push_pair(1, -8'sd128, -8'sd128, (i == 4), st);
    end
    push_pair(1, 8'sd1, 8'sd1, 1'b1, st);
    for (int i = 0; i < 2; i++) begin
      get_result(1, d, o, ok);
      checks++;
      if (!ok || exp_data_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL ovf_result%0d: got no result expected a queued result", i);
      end else begin
        e  = exp_data_q.pop_front();
        eo = exp_ovf_q.pop_front();
        if (d !== e || o !== eo) begin
          failures++;
          $display("[TB] FAIL ovf_result%0d: got %0d ovf=%0b expected %0d ovf=%0b", i, d, o, e, eo);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    bit     st;
    bit     ok;
    bit     o;
    longint d;
    int     base;
    int     n;
    base = start_cnt0;
    push_pair(0, 8'sd1, 8'sd1, 1'b0, st);
    push_pair(0, 8'sd1, 8'sd1, 1'b0, st);
    push_pair(0, 8'sd1, 8'sd1, 1'b1, st);
    n = 0;
    while (start_cnt0 < base + 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready0, mul_start0, mul_a0, mul_b0, res_valid0, res_data0, res_ovf0, busy0} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 24'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midrun_reset: got rdy=%0b st=%0b a=%0h b=%0h v=%0b d=%0h ovf=%0b busy=%0b expected 1 0 0 0 0 0 0 0",
               in_ready0, mul_start0, mul_a0, mul_b0, res_valid0, res_data0, res_ovf0, busy0);
    end
    exp_data_q.delete();
    exp_ovf_q.delete();
    macc = 0;
    movf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_pair(0, 8'sd2, 8'sd2, 1'b1, st);
    get_result(0, d, o, ok);
    checks++;
    if (!ok || exp_data_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL after_reset: got no result expected 4");
    end else if (d !== exp_data_q.pop_front() || o !== exp_ovf_q.pop_front() || d !== 4) begin
      failures++;
      $display("[TB] FAIL after_reset: got %0d ovf=%0b expected 4 ovf=0", d, o);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_vector();
    test_back_to_back();
    test_hold_result();
    test_overflow();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish within 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
